// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// Module  : parking_pkg
// Brief   : Shared encodings for the parking ledger (status, FSM state, op).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package parking_pkg;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_BAD_SLOT   = 2'd1,
    ST_ALREADY_IN = 2'd2,
    ST_NOT_IN     = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic c_OP_CHECK_IN  = 1'b0;
  localparam logic c_OP_CHECK_OUT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fee_accum.sv
// ---------------------------------------------------------------------------
// Module  : fee_accum
// Brief   : Per-unit fee accumulator run during the ledger's CALC phase.
//           FEE_CAP_EN enables early exit once SAT_LIMIT is reached.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fee_accum
  import parking_pkg::*;
#(
  parameter int TIME_W     = 11,
  parameter int FEE_W      = 11,
  parameter int UNIT_TICKS = 60,
  parameter int RATE       = 1,
  parameter int SAT_LIMIT  = 2047
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [TIME_W-1:0] i_elapsed,
  output logic              o_done,
  output logic [FEE_W-1:0]  o_fee
);

  localparam logic [FEE_W:0]  c_LIMIT = (FEE_W+1)'(SAT_LIMIT);
  localparam logic [FEE_W:0]  c_RATE  = (FEE_W+1)'(RATE);
  localparam logic [TIME_W:0] c_UNIT  = (TIME_W+1)'(UNIT_TICKS);

  logic              r_busy;
  logic [TIME_W-1:0] r_rem;
  logic [FEE_W-1:0]  r_acc;

  logic [FEE_W:0]    w_sum;
  logic [FEE_W-1:0]  w_acc_next;
  logic [TIME_W-1:0] w_rem_next;
  logic              w_capped;

  assign w_sum      = {1'b0, r_acc} + c_RATE;
  assign w_acc_next = (w_sum > c_LIMIT) ? c_LIMIT[FEE_W-1:0] : w_sum[FEE_W-1:0];
  // A partial final unit is still billed in full, so remaining floors at zero.
  assign w_rem_next = ({1'b0, r_rem} > c_UNIT) ? (r_rem - c_UNIT[TIME_W-1:0]) : '0;

`ifdef FEE_CAP_EN
  assign w_capped = ({1'b0, r_acc} >= c_LIMIT);
`else
  assign w_capped = 1'b0;
`endif

  assign o_done = r_busy && ((r_rem == '0) || w_capped);
  assign o_fee  = r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_elapsed;
      r_acc  <= '0;
    end else if (o_done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_acc  <= w_acc_next;
      r_rem  <= w_rem_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/parking_ledger.sv
// ---------------------------------------------------------------------------
// Module  : parking_ledger
// Brief   : NUM_SLOTS-bay check-in/check-out ledger with sequential fee calc.
//           Optional macro FEE_CAP_EN caps the fee at MAX_FEE.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module parking_ledger
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS  = 6,
  parameter int TIME_W     = 11,
  parameter int FEE_W      = 11,
  parameter int UNIT_TICKS = 60,
  parameter int RATE       = 1,
  parameter int MAX_FEE    = 500,
  localparam int SLOT_W    = $clog2(NUM_SLOTS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    timer,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [SLOT_W-1:0]    req_slot,
  output logic                 resp_valid,
  output logic [1:0]           resp_status,
  output logic [FEE_W-1:0]     resp_fee,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]    free_count
);

  localparam int              c_FULL = (1 << FEE_W) - 1;
  localparam logic [SLOT_W-1:0] c_ONE = SLOT_W'(1);

`ifdef FEE_CAP_EN
  localparam int c_SAT = (MAX_FEE < c_FULL) ? MAX_FEE : c_FULL;
`else
  localparam int c_SAT = c_FULL;
  // MAX_FEE is inert in this build; the block only keeps it referenced.
  if (MAX_FEE < 0) begin : g_max_fee_inert
  end
`endif

  state_e              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  status_e             r_status;
  logic [FEE_W-1:0]    r_fee;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [TIME_W-1:0]   r_entry [NUM_SLOTS];
  logic [SLOT_W-1:0]   r_free;
  logic [TIME_W-1:0]   r_time;
  logic                r_op;
  logic [SLOT_W-1:0]   r_slot;

  logic                w_bad;
  logic                w_hit_occ;
  logic [TIME_W-1:0]   w_hit_entry;
  logic [TIME_W-1:0]   w_elapsed;
  logic                w_start;
  logic                w_calc_done;
  logic [FEE_W-1:0]    w_calc_fee;

  always_comb begin
    w_bad       = (r_slot == '0) || (r_slot > SLOT_W'(NUM_SLOTS));
    w_hit_occ   = 1'b0;
    w_hit_entry = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_slot == SLOT_W'(i + 1)) begin
        w_hit_occ   = r_occ[i];
        w_hit_entry = r_entry[i];
      end
    end
  end

  // Modular subtraction absorbs a single timer wrap between entry and exit.
  assign w_elapsed = r_time - w_hit_entry;
  assign w_start   = (r_state == S_CHECK) && !w_bad &&
                     (r_op == c_OP_CHECK_OUT) && w_hit_occ;

  fee_accum #(
    .TIME_W     (TIME_W),
    .FEE_W      (FEE_W),
    .UNIT_TICKS (UNIT_TICKS),
    .RATE       (RATE),
    .SAT_LIMIT  (c_SAT)
  ) u_fee_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_elapsed (w_elapsed),
    .o_done    (w_calc_done),
    .o_fee     (w_calc_fee)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_status     <= ST_OK;
      r_fee        <= '0;
      r_occ        <= '0;
      r_free       <= SLOT_W'(NUM_SLOTS);
      r_time       <= '0;
      r_op         <= c_OP_CHECK_IN;
      r_slot       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_time      <= timer;
            r_op        <= req_op;
            r_slot      <= req_slot;
            r_req_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_bad) begin
            r_status     <= ST_BAD_SLOT;
            r_fee        <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_op == c_OP_CHECK_IN) begin
            r_fee        <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
            if (w_hit_occ) begin
              r_status <= ST_ALREADY_IN;
            end else begin
              r_status <= ST_OK;
              r_free   <= r_free - c_ONE;
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_slot == SLOT_W'(i + 1)) begin
                  r_occ[i]   <= 1'b1;
                  r_entry[i] <= r_time;
                end
              end
            end
          end else if (!w_hit_occ) begin
            r_status     <= ST_NOT_IN;
            r_fee        <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_free  <= r_free + c_ONE;
            r_state <= S_CALC;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (r_slot == SLOT_W'(i + 1)) begin
                r_occ[i] <= 1'b0;
              end
            end
          end
        end

        S_CALC: begin
          if (w_calc_done) begin
            r_status     <= ST_OK;
            r_fee        <= w_calc_fee;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_status = r_status;
  assign resp_fee    = r_fee;
  assign occupied    = r_occ;
  assign free_count  = r_free;

endmodule

`default_nettype wire
